lcd_byte_writer: RTL and testbench

LCD_BYTE_WRITER -- requirements
Module: lcd_byte_writer

---
 rtl/lcd_byte_writer.sv | 203 ++++++++++++++++++++
 tb/tb_lcd_byte_writer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_byte_writer.sv
// Write-only 4-bit HD44780-style LCD byte writer: runs the power-up nibble init after reset, then
// sends each accepted byte as a high nibble and a low nibble with programmable timing.
module lcd_byte_writer #(
    parameter int unsigned P_SETUP    = 2,
    parameter int unsigned P_EN       = 12,
    parameter int unsigned P_HOLD     = 1,
    parameter int unsigned P_NIB_GAP  = 50,
    parameter int unsigned P_BYTE_GAP = 2000,
    parameter int unsigned P_POWERUP  = 750000,
    parameter int unsigned P_INIT1    = 205000,
    parameter int unsigned P_INIT2    = 5000,
    parameter int unsigned P_INIT3    = 2000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iWrite,
    input  logic [7:0] iData,
    input  logic       iRS,
    output logic       oReady,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_ReadWrite,
    output logic       oLCD_StrataFlashControl,
    output logic [3:0] oLCD_Data
);

    localparam int unsigned CW = 20;

    localparam logic [CW-1:0] L_SETUP    = CW'(P_SETUP);
    localparam logic [CW-1:0] L_EN       = CW'(P_EN);
    localparam logic [CW-1:0] L_HOLD     = CW'(P_HOLD);
    localparam logic [CW-1:0] L_NIB_GAP  = CW'(P_NIB_GAP);
    localparam logic [CW-1:0] L_BYTE_GAP = CW'(P_BYTE_GAP);
    localparam logic [CW-1:0] L_POWERUP  = CW'(P_POWERUP);
    localparam logic [CW-1:0] L_INIT1    = CW'(P_INIT1);
    localparam logic [CW-1:0] L_INIT2    = CW'(P_INIT2);
    localparam logic [CW-1:0] L_INIT3    = CW'(P_INIT3);

    typedef enum logic [3:0] {
        INIT_WAIT,
        INIT_SETUP,
        INIT_EN,
        INIT_HOLD,
        INIT_GAP,
        IDLE,
        HI_SETUP,
        HI_EN,
        HI_HOLD,
        NIB_GAP,
        LO_SETUP,
        LO_EN,
        LO_HOLD,
        BYTE_GAP
    } state_t;

    state_t        r_state, w_state_d;
    logic [CW-1:0] r_cnt, w_cnt_d;
    logic [CW-1:0] w_limit;
    logic          w_last;
    logic [1:0]    r_init_idx, w_init_idx_d;
    logic [7:0]    r_byte, w_byte_d;
    logic          r_rs, w_rs_d;
    logic          w_accept;

    logic          r_ready, w_ready_d;
    logic          r_en, w_en_d;
    logic          r_rs_out, w_rs_out_d;
    logic [3:0]    r_data, w_data_d;

    // Dwell time of the current state.
    always_comb begin
        w_limit = 20'd1;
        case (r_state)
            INIT_WAIT:                      w_limit = L_POWERUP;
            INIT_SETUP, HI_SETUP, LO_SETUP: w_limit = L_SETUP;
            INIT_EN, HI_EN, LO_EN:          w_limit = L_EN;
            INIT_HOLD, HI_HOLD, LO_HOLD:    w_limit = L_HOLD;
            INIT_GAP: begin
                if (r_init_idx == 2'd0) begin
                    w_limit = L_INIT1;
                end else if (r_init_idx == 2'd1) begin
                    w_limit = L_INIT2;
                end else begin
                    w_limit = L_INIT3;
                end
            end
            NIB_GAP:                        w_limit = L_NIB_GAP;
            BYTE_GAP:                       w_limit = L_BYTE_GAP;
            default:                        w_limit = 20'd1;
        endcase
    end

    assign w_last = (r_cnt == (w_limit - 20'd1));

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt + 20'd1;
        w_init_idx_d = r_init_idx;
        w_accept     = 1'b0;
        if (r_state == IDLE) begin
            w_cnt_d = '0;
            if (iWrite) begin
                w_accept  = 1'b1;
                w_state_d = HI_SETUP;
            end
        end else if (w_last) begin
            w_cnt_d = '0;
            case (r_state)
                INIT_WAIT:  w_state_d = INIT_SETUP;
                INIT_SETUP: w_state_d = INIT_EN;
                INIT_EN:    w_state_d = INIT_HOLD;
                INIT_HOLD:  w_state_d = INIT_GAP;
                INIT_GAP: begin
                    if (r_init_idx == 2'd3) begin
                        w_state_d = IDLE;
                    end else begin
                        w_init_idx_d = r_init_idx + 2'd1;
                        w_state_d    = INIT_SETUP;
                    end
                end
                HI_SETUP:   w_state_d = HI_EN;
                HI_EN:      w_state_d = HI_HOLD;
                HI_HOLD:    w_state_d = NIB_GAP;
                NIB_GAP:    w_state_d = LO_SETUP;
                LO_SETUP:   w_state_d = LO_EN;
                LO_EN:      w_state_d = LO_HOLD;
                LO_HOLD:    w_state_d = BYTE_GAP;
                BYTE_GAP:   w_state_d = IDLE;
                default:    w_state_d = INIT_WAIT;
            endcase
        end
    end

    assign w_byte_d = w_accept ? iData : r_byte;
    assign w_rs_d   = w_accept ? iRS : r_rs;

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        w_ready_d  = 1'b0;
        w_en_d     = 1'b0;
        w_rs_out_d = 1'b0;
        w_data_d   = 4'h0;
        case (w_state_d)
            IDLE: w_ready_d = 1'b1;
            INIT_SETUP, INIT_EN, INIT_HOLD: begin
                w_en_d   = (w_state_d == INIT_EN);
                w_data_d = (w_init_idx_d == 2'd3) ? 4'h2 : 4'h3;
            end
            HI_SETUP, HI_EN, HI_HOLD: begin
                w_en_d     = (w_state_d == HI_EN);
                w_rs_out_d = w_rs_d;
                w_data_d   = w_byte_d[7:4];
            end
            NIB_GAP: w_rs_out_d = w_rs_d;
            LO_SETUP, LO_EN, LO_HOLD: begin
                w_en_d     = (w_state_d == LO_EN);
                w_rs_out_d = w_rs_d;
                w_data_d   = w_byte_d[3:0];
            end
            default: begin
                w_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state    <= INIT_WAIT;
            r_cnt      <= '0;
            r_init_idx <= 2'd0;
            r_byte     <= 8'h00;
            r_rs       <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_init_idx <= w_init_idx_d;
            r_byte     <= w_byte_d;
            r_rs       <= w_rs_d;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_ready  <= 1'b0;
            r_en     <= 1'b0;
            r_rs_out <= 1'b0;
            r_data   <= 4'h0;
        end else begin
            r_ready  <= w_ready_d;
            r_en     <= w_en_d;
            r_rs_out <= w_rs_out_d;
            r_data   <= w_data_d;
        end
    end

    assign oReady                  = r_ready;
    assign oLCD_Enabled            = r_en;
    assign oLCD_RegisterSelect     = r_rs_out;
    assign oLCD_Data               = r_data;
    assign oLCD_ReadWrite          = 1'b0;
    assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Bench for lcd_byte_writer: expected pin waveforms are built as per-cycle queues from the
// phase durations and compared every cycle, with random bytes and ignored-write noise.
module tb_lcd_byte_writer;

    localparam int unsigned S  = 2;
    localparam int unsigned E  = 3;
    localparam int unsigned H  = 1;
    localparam int unsigned NG = 4;
    localparam int unsigned BG = 6;
    localparam int unsigned PU = 10;
    localparam int unsigned I1 = 8;
    localparam int unsigned I2 = 5;
    localparam int unsigned I3 = 4;
    localparam int unsigned T_BYTE   = 2 * (S + E + H) + NG + BG;
    localparam int unsigned INIT_LEN = PU + 4 * (S + E + H) + I1 + I2 + 2 * I3;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       iWrite = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       iRS = 1'b0;
    logic       oReady;
    logic       oLCD_Enabled;
    logic       oLCD_RegisterSelect;
    logic       oLCD_ReadWrite;
    logic       oLCD_StrataFlashControl;
    logic [3:0] oLCD_Data;

    lcd_byte_writer #(
        .P_SETUP   (S),
        .P_EN      (E),
        .P_HOLD    (H),
        .P_NIB_GAP (NG),
        .P_BYTE_GAP(BG),
        .P_POWERUP (PU),
        .P_INIT1   (I1),
        .P_INIT2   (I2),
        .P_INIT3   (I3)
    ) dut (
        .Clock                  (Clock),
        .Reset                  (Reset),
        .iWrite                 (iWrite),
        .iData                  (iData),
        .iRS                    (iRS),
        .oReady                 (oReady),
        .oLCD_Enabled           (oLCD_Enabled),
        .oLCD_RegisterSelect    (oLCD_RegisterSelect),
        .oLCD_ReadWrite         (oLCD_ReadWrite),
        .oLCD_StrataFlashControl(oLCD_StrataFlashControl),
        .oLCD_Data              (oLCD_Data)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic       rdy;
        logic       en;
        logic       rs;
        logic [3:0] dat;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_obs(input string tag, input obs_t e);
        chk({tag, ".ready"}, {3'b0, oReady}, {3'b0, e.rdy});
        chk({tag, ".en"}, {3'b0, oLCD_Enabled}, {3'b0, e.en});
        chk({tag, ".rs"}, {3'b0, oLCD_RegisterSelect}, {3'b0, e.rs});
        chk({tag, ".data"}, oLCD_Data, e.dat);
        chk({tag, ".rw"}, {3'b0, oLCD_ReadWrite}, 4'h0);
        chk({tag, ".sf"}, {3'b0, oLCD_StrataFlashControl}, 4'h1);
    endtask

    task automatic push(input int unsigned n, input logic en, input logic rs,
                        input logic [3:0] dat);
        obs_t o;
        o.rdy = 1'b0;
        o.en  = en;
        o.rs  = rs;
        o.dat = dat;
        for (int i = 0; i < int'(n); i++) exp_q.push_back(o);
    endtask

    // Init: power-up wait, then nibbles 3,3,3,2 each followed by its own gap.
    task automatic build_init();
        logic [3:0] nib;
        int unsigned gap;
        push(PU, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            nib = (i == 3) ? 4'h2 : 4'h3;
            gap = (i == 0) ? I1 : (i == 1) ? I2 : I3;
            push(S, 1'b0, 1'b0, nib);
            push(E, 1'b1, 1'b0, nib);
            push(H, 1'b0, 1'b0, nib);
            push(gap, 1'b0, 1'b0, 4'h0);
        end
    endtask

    task automatic build_byte(input logic [7:0] b, input logic rs);
        push(S, 1'b0, rs, b[7:4]);
        push(E, 1'b1, rs, b[7:4]);
        push(H, 1'b0, rs, b[7:4]);
        push(NG, 1'b0, rs, 4'h0);
        push(S, 1'b0, rs, b[3:0]);
        push(E, 1'b1, rs, b[3:0]);
        push(H, 1'b0, rs, b[3:0]);
        push(BG, 1'b0, 1'b0, 4'h0);
    endtask

    // Consume n expected cycles; mode 0 quiet, 1 random noise, 2 write 0xFF, 3 hold write 0x80.
    task automatic play(input string tag, input int mode, input int n);
        obs_t e;
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            check_obs(tag, e);
            case (mode)
                1: begin
                    iWrite = 1'($urandom_range(0, 1));
                    iData  = 8'($urandom);
                    iRS    = 1'($urandom);
                end
                2: begin
                    iWrite = 1'b1;
                    iData  = 8'hFF;
                    iRS    = 1'b0;
                end
                3: begin
                    iWrite = 1'b1;
                    iData  = 8'h80;
                    iRS    = 1'b0;
                end
                default: iWrite = 1'b0;
            endcase
            @(negedge Clock);
        end
    endtask

    task automatic expect_ready(input string tag);
        obs_t o;
        o = '0;
        o.rdy = 1'b1;
        check_obs(tag, o);
    endtask

    // Accept on the next rising edge; return on the negedge of the first byte cycle.
    task automatic send(input logic [7:0] b, input logic rs);
        iData  = b;
        iRS    = rs;
        iWrite = 1'b1;
        @(negedge Clock);
        build_byte(b, rs);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rrs;
        int unsigned idle;

        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        check_obs("reset", obs_t'(7'b0));

        // Release reset and follow the full init with writes hammering the busy port.
        Reset = 1'b0;
        build_init();
        play("init", 1, INIT_LEN);
        expect_ready("init_done");

        // 0x41 as data, with 0xFF writes pushed while busy.
        send(8'h41, 1'b1);
        play("byte41", 2, T_BYTE);
        expect_ready("byte41_done");

        // Write held high: 0x01 then 0x80 back to back.
        send(8'h01, 1'b0);
        play("byte01", 3, T_BYTE);
        expect_ready("byte01_done");
        @(negedge Clock);
        build_byte(8'h80, 1'b0);
        play("byte80", 0, T_BYTE);
        expect_ready("byte80_done");

        for (int k = 0; k < 8; k++) begin
            idle = $urandom_range(0, 3);
            iWrite = 1'b0;
            for (int j = 0; j < int'(idle); j++) begin
                @(negedge Clock);
                expect_ready("rand_idle");
            end
            rb  = 8'($urandom);
            rrs = 1'($urandom);
            send(rb, rrs);
            play("rand_byte", 1, T_BYTE);
            expect_ready("rand_done");
        end

        // Reset landing in the second cycle of the low-nibble enable.
        send(8'h5A, 1'b1);
        play("abort_byte", 0, S + E + H + NG + S + 1);
        check_obs("abort_lo_en", exp_q[0]);
        Reset = 1'b1;
        #1;
        check_obs("abort_async", obs_t'(7'b0));
        exp_q.delete();
        @(negedge Clock);
        check_obs("abort_held", obs_t'(7'b0));
        Reset = 1'b0;
        build_init();
        play("reinit", 1, INIT_LEN);
        expect_ready("reinit_done");
        iWrite = 1'b0;
        @(negedge Clock);
        expect_ready("reinit_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
